// File: rtl/udp_tx_scheduler.sv
// rtl/udp_tx_scheduler.sv - round-robin UDP TX scheduler: 8-byte header generation plus payload streaming
// Optional UDP_TX_FIXED_PRIO_EN: requester 0 always wins arbitration, the rest share round-robin.
module udp_tx_scheduler #(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = 1472
) (
    input  logic                 clock,
    input  logic                 sclr_n,
    input  logic [15:0]          BOARD_PORT,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*16-1:0]   req_len,
    input  logic [NREQ*16-1:0]   req_dst_port,
    input  logic [NREQ*8-1:0]    req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      data_rd,
    input  logic                 tx_ready,
    output logic [7:0]           dataout,
    output logic                 dataen,
    output logic                 sop,
    output logic                 eop
);
    localparam int PW = $clog2(NREQ);
`ifdef UDP_TX_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_HDR, S_PAY, S_GAP} state_t;
    state_t state, state_nxt;

    logic [PW-1:0] ptr, gidx, win_idx;
    logic          win_found;
    logic [15:0]   len_r, dst_r, cnt, len_sel, dst_sel, len_clip;
    logic [7:0]    pay_byte, nxt_byte;
    logic          adv, nxt_sop, nxt_eop;

    // First set request at or after the pointer; with fixed priority channel 0 is
    // excluded from the rotation and overrides it instead.
    always_comb begin
        int          idx;
        logic [PW-1:0] i_n;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        i_n       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            i_n = PW'(idx);
            if (!win_found && req[i_n] && (idx != 0 || !FIXED)) begin
                win_found = 1'b1;
                win_idx   = i_n;
            end
        end
        if (FIXED && req[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
    end

    always_comb begin
        len_sel  = '0;
        dst_sel  = '0;
        pay_byte = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_idx) begin
                len_sel = req_len[i*16 +: 16];
                dst_sel = req_dst_port[i*16 +: 16];
            end
            if (PW'(i) == gidx)
                pay_byte = req_data[i*8 +: 8];
        end
    end

    assign len_clip = (len_sel > 16'(MAX_LEN)) ? 16'(MAX_LEN) : len_sel;

    always_ff @(posedge clock) begin
        if (!sclr_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (win_found) state_nxt = S_ARB;
            S_ARB:  state_nxt = S_HDR;
            S_HDR:  if (tx_ready && cnt == 16'd7)
                        state_nxt = (len_r == 16'd0) ? S_GAP : S_PAY;
            S_PAY:  if (tx_ready && cnt == len_r - 16'd1) state_nxt = S_GAP;
            S_GAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        adv      = 1'b0;
        data_rd  = '0;
        nxt_byte = 8'h00;
        nxt_sop  = 1'b0;
        nxt_eop  = 1'b0;
        if (state == S_HDR) begin
            adv     = tx_ready;
            nxt_sop = (cnt == 16'd0);
            nxt_eop = (cnt == 16'd7) && (len_r == 16'd0);
            case (cnt[2:0])
                3'd0:    nxt_byte = BOARD_PORT[15:8];
                3'd1:    nxt_byte = BOARD_PORT[7:0];
                3'd2:    nxt_byte = dst_r[15:8];
                3'd3:    nxt_byte = dst_r[7:0];
                3'd4:    nxt_byte = 8'((len_r + 16'd8) >> 8);
                3'd5:    nxt_byte = 8'(len_r + 16'd8);
                default: nxt_byte = 8'h00;
            endcase
        end else if (state == S_PAY) begin
            adv      = tx_ready;
            nxt_byte = pay_byte;
            nxt_eop  = (cnt == len_r - 16'd1);
            if (tx_ready)
                data_rd = gnt;
        end
    end

    always_ff @(posedge clock) begin
        if (!sclr_n) begin
            gnt     <= '0;
            gidx    <= '0;
            ptr     <= '0;
            len_r   <= '0;
            dst_r   <= '0;
            cnt     <= '0;
            dataout <= 8'h00;
            dataen  <= 1'b0;
            sop     <= 1'b0;
            eop     <= 1'b0;
        end else begin
            dataen <= adv;
            sop    <= adv && nxt_sop;
            eop    <= adv && nxt_eop;
            if (adv)
                dataout <= nxt_byte;
            case (state)
                S_IDLE: if (win_found) begin
                    gnt   <= NREQ'(1) << win_idx;
                    gidx  <= win_idx;
                    len_r <= len_clip;
                    dst_r <= dst_sel;
                    cnt   <= '0;
                end
                S_HDR: if (tx_ready) cnt <= (cnt == 16'd7) ? 16'd0 : cnt + 16'd1;
                S_PAY: if (tx_ready) cnt <= cnt + 16'd1;
                S_GAP: begin
                    gnt <= '0;
                    if (!(FIXED && gidx == '0))
                        ptr <= (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_udp_tx_scheduler.sv
// tb/tb_udp_tx_scheduler.sv - scoreboard bench for udp_tx_scheduler
module tb_udp_tx_scheduler;
    localparam int NREQ = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                sclr_n;
    logic [15:0]         board_port;
    logic [NREQ-1:0]     req;
    logic [NREQ*16-1:0]  req_len, req_dst_port;
    logic [NREQ*8-1:0]   req_data;
    logic [NREQ-1:0]     gnt, data_rd;
    logic                tx_ready;
    logic [7:0]          dataout;
    logic                dataen, sop, eop;

    udp_tx_scheduler #(.NREQ(NREQ), .MAX_LEN(1472)) dut (
        .clock(clock), .sclr_n(sclr_n), .BOARD_PORT(board_port), .req(req),
        .req_len(req_len), .req_dst_port(req_dst_port), .req_data(req_data),
        .gnt(gnt), .data_rd(data_rd), .tx_ready(tx_ready), .dataout(dataout),
        .dataen(dataen), .sop(sop), .eop(eop)
    );

    int errors = 0;
    int checks = 0;
    logic [9:0]      sb[$];
    logic [NREQ-1:0] gnt_log[$];
    int              gap_log[$];
    logic [7:0]      rd_cnt[NREQ];
    int              drd_tot[NREQ] = '{default: 0};
    logic [7:0]      exp_next[NREQ] = '{default: 8'h00};

    // FWFT sources: channel i presents i*64 + (bytes consumed since reset)
    always @(posedge clock) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!sclr_n)
                rd_cnt[i] <= 8'h00;
            else if (data_rd[i]) begin
                rd_cnt[i]  <= rd_cnt[i] + 8'd1;
                drd_tot[i] <= drd_tot[i] + 1;
            end
        end
    end

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NREQ; i++)
            req_data[i*8 +: 8] = 8'(i * 64) + rd_cnt[i];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dgram(input int ch, input int len);
        int         l;
        logic [15:0] tl, dst;
        logic [7:0]  hdr[8];
        l   = (len > 1472) ? 1472 : len;
        tl  = 16'(l + 8);
        dst = req_dst_port[ch*16 +: 16];
        hdr = '{board_port[15:8], board_port[7:0], dst[15:8], dst[7:0], tl[15:8], tl[7:0], 8'h00, 8'h00};
        for (int k = 0; k < 8; k++)
            sb.push_back({k == 0, (k == 7) && (l == 0), hdr[k]});
        for (int p = 0; p < l; p++) begin
            sb.push_back({1'b0, p == l - 1, 8'(ch * 64) + exp_next[ch]});
            exp_next[ch] = exp_next[ch] + 8'd1;
        end
    endtask

    // Monitor: pops the scoreboard on every valid byte and logs grant starts
    initial begin
        logic [9:0]      e;
        logic [NREQ-1:0] prev_gnt;
        int              low_cnt;
        prev_gnt = '0;
        low_cnt  = 0;
        forever begin
            @(negedge clock);
            if (dataen) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got sop=%0b eop=%0b data=%0h with empty scoreboard", sop, eop, dataout);
                end else begin
                    e = sb.pop_front();
                    if ({sop, eop, dataout} !== e) begin
                        errors++;
                        $display("FAIL stream_byte: got sop=%0b eop=%0b data=%0h expected sop=%0b eop=%0b data=%0h",
                                 sop, eop, dataout, e[9], e[8], e[7:0]);
                    end
                end
            end
            if (data_rd != '0)
                check("data_rd_onehot_granted", {31'd0, ($onehot(data_rd) && ((data_rd & ~gnt) == '0))}, 32'd1);
            if (gnt != '0 && prev_gnt == '0) begin
                gnt_log.push_back(gnt);
                gap_log.push_back(low_cnt);
            end
            low_cnt  = (gnt == '0) ? low_cnt + 1 : 0;
            prev_gnt = gnt;
        end
    end

    task automatic do_reset();
        sclr_n = 1'b0;
        req    = '0;
        repeat (2) @(negedge clock);
        sb.delete();
        for (int i = 0; i < NREQ; i++) exp_next[i] = 8'h00;
        sclr_n = 1'b1;
        @(negedge clock);
        gnt_log.delete();
        gap_log.delete();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((sb.size() != 0 || gnt != '0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d bytes still pending after %0d cycles", name, sb.size(), budget);
        end
    endtask

    task automatic wait_grants(input string name, input int cnt, input int budget);
        int n = 0;
        while (gnt_log.size() < cnt && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d grants seen, %0d required", name, gnt_log.size(), cnt);
        end
    endtask

    task automatic wait_rd(input int ch, input int base, input int cnt, input int budget);
        int n = 0;
        while (drd_tot[ch] - base < cnt && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_rd_timeout: ch%0d consumed %0d of %0d", ch, drd_tot[ch] - base, cnt);
        end
    endtask

    initial begin
        int base;
        logic [NREQ-1:0] exp_gnt[$];
        sclr_n       = 1'b0;
        req          = '0;
        tx_ready     = 1'b1;
        board_port   = 16'h0400;
        req_len      = '0;
        req_dst_port = {16'h3000, 16'h2000, 16'h1F90, 16'h1000};
        repeat (2) @(negedge clock);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_data_rd", 32'(data_rd), 32'd0);
        check("rst_dataout", 32'(dataout), 32'd0);
        check("rst_dataen", 32'(dataen), 32'd0);
        check("rst_sop", 32'(sop), 32'd0);
        check("rst_eop", 32'(eop), 32'd0);
        sclr_n = 1'b1;
        @(negedge clock);

        // 1: single datagram, latency, req dropped after grant
        base = drd_tot[1];
        req_len[16 +: 16] = 16'd4;
        push_dgram(1, 4);
        req = 4'b0010;
        @(negedge clock);
        check("t1_gnt_latency", 32'(gnt), 32'h2);
        req = '0;
        @(negedge clock);
        check("t1_no_early_byte", 32'(dataen), 32'd0);
        @(negedge clock);
        check("t1_sop_latency", {30'd0, sop, dataen}, 32'd3);
        wait_drain("t1", 100);
        check("t1_data_rd_count", 32'(drd_tot[1] - base), 32'd4);

`ifndef UDP_TX_FIXED_PRIO_EN
        // 2: held requests 1011 from pointer 0
        do_reset();
        req_len = {16'd2, 16'd2, 16'd2, 16'd2};
        push_dgram(0, 2); push_dgram(1, 2); push_dgram(3, 2); push_dgram(0, 2);
        req = 4'b1011;
        wait_grants("t2", 4, 300);
        req = '0;
        wait_drain("t2", 200);
        exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        for (int k = 0; k < 4; k++) begin
            if (k < gnt_log.size()) check($sformatf("t2_grant_%0d", k), 32'(gnt_log[k]), 32'(exp_gnt[k]));
            if (k > 0 && k < gap_log.size()) check($sformatf("t2_gap_%0d", k), 32'(gap_log[k]), 32'd1);
        end
`endif

        // 3: zero-length datagram on channel 2
        base = drd_tot[2];
        req_len[32 +: 16] = 16'd0;
        push_dgram(2, 0);
        req = 4'b0100;
        wait_grants("t3", gnt_log.size() + 1, 50);
        req = '0;
        wait_drain("t3", 100);
        check("t3_no_data_rd", 32'(drd_tot[2] - base), 32'd0);

        // 4: tx_ready held low for three cycles at payload byte 2
        base = drd_tot[3];
        req_len[48 +: 16] = 16'd6;
        push_dgram(3, 6);
        req = 4'b1000;
        wait_rd(3, base, 2, 100);
        req = '0;
        tx_ready = 1'b0;
        #1;
        check("t4_stall_rd_0", 32'(data_rd), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            check($sformatf("t4_stall_dataen_%0d", k), 32'(dataen), 32'd0);
            if (k < 3) check($sformatf("t4_stall_rd_%0d", k), 32'(data_rd), 32'd0);
        end
        tx_ready = 1'b1;
        wait_drain("t4", 100);
        check("t4_data_rd_count", 32'(drd_tot[3] - base), 32'd6);

`ifndef UDP_TX_FIXED_PRIO_EN
        // 5: oversized request is clipped, then a reset aborts a datagram mid-payload
        base = drd_tot[0];
        req_len[0 +: 16] = 16'd2000;
        push_dgram(0, 2000);
        req = 4'b0001;
        wait_grants("t5", gnt_log.size() + 1, 50);
        req = '0;
        wait_drain("t5", 4000);
        check("t5_clipped_count", 32'(drd_tot[0] - base), 32'd1472);

        base = drd_tot[2];
        req_len[32 +: 16] = 16'd20;
        push_dgram(2, 20);
        req = 4'b0100;
        wait_rd(2, base, 5, 100);
        sclr_n = 1'b0;
        req    = '0;
        @(negedge clock);
        check("t5_abort_outputs", {gnt, data_rd, dataout, dataen, sop, eop}, 32'd0);
        sb.delete();
        for (int i = 0; i < NREQ; i++) exp_next[i] = 8'h00;
        sclr_n = 1'b1;
        gnt_log.delete();
        req_len[0 +: 16]  = 16'd1;
        req_len[32 +: 16] = 16'd1;
        push_dgram(0, 1);
        req = 4'b0101;
        wait_grants("t5b", 1, 50);
        req = '0;
        wait_drain("t5b", 100);
        if (gnt_log.size() > 0) check("t5_ptr_after_reset", 32'(gnt_log[0]), 32'h1);
`else
        // 6: fixed priority for channel 0, round-robin over the rest
        do_reset();
        req_len = {16'd1, 16'd1, 16'd1, 16'd1};
        push_dgram(0, 1); push_dgram(0, 1); push_dgram(0, 1);
        req = 4'b0111;
        wait_grants("t6a", 3, 200);
        req = 4'b0110;
        push_dgram(1, 1); push_dgram(2, 1); push_dgram(1, 1); push_dgram(2, 1);
        wait_grants("t6b", 7, 300);
        req = '0;
        wait_drain("t6", 200);
        exp_gnt = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b0010, 4'b0100};
        for (int k = 0; k < 7; k++)
            if (k < gnt_log.size()) check($sformatf("t6_grant_%0d", k), 32'(gnt_log[k]), 32'(exp_gnt[k]));
`endif

        repeat (3) @(negedge clock);
        check("end_scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
